// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the data-RAM access controller.
package ram_ctrl_pkg;

  localparam int unsigned RamAw    = 8;   // RAM address width
  localparam int unsigned RamDw    = 16;  // RAM data width
  localparam int unsigned RamRdLat = 1;   // addr edge to dout valid, in cycles
  localparam int unsigned RamLenw  = 4;   // burst length field width

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain
  } ctrl_state_e;

  // Travels alongside each issued read address until its data returns.
  typedef struct packed {
    logic valid;
    logic last;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line for read tags, matching the RAM read latency.
module rd_tag_pipe
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned Depth = RamRdLat
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    flush,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [Depth];

  // Shift tags one stage per cycle; flush and reset clear every stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int unsigned i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[Depth-1];

endmodule

// File: rtl/ram_access_ctrl.sv
// Initiator for the single-port synchronous data RAM: single writes and
// pipelined read bursts of 1..2^LENW consecutive words.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned AW     = RamAw,
  parameter int unsigned DW     = RamDw,
  parameter int unsigned RD_LAT = RamRdLat,
  parameter int unsigned LENW   = RamLenw
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [LENW-1:0] req_len,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            rd_last,
  output logic            busy,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout
);

  ctrl_state_e     state_q;
  logic            ram_we_q;
  logic [AW-1:0]   ram_addr_q;
  logic [DW-1:0]   ram_din_q;
  logic [LENW-1:0] cnt_q;

  rd_tag_t tag_in;
  rd_tag_t tag_out;

  // Request handshake and the RAM command sequence; all RAM pins are registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      cnt_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            ram_addr_q <= req_addr;
            if (req_we) begin
              ram_we_q  <= 1'b1;
              ram_din_q <= req_wdata;
              state_q   <= StWrite;
            end else begin
              cnt_q   <= req_len;
              state_q <= StRead;
            end
          end
        end
        StWrite: begin
          ram_we_q <= 1'b0;
          state_q  <= StIdle;
        end
        StRead: begin
          if (cnt_q == '0) begin
            state_q <= StDrain;
          end else begin
            ram_addr_q <= ram_addr_q + AW'(1);
            cnt_q      <= cnt_q - LENW'(1);
          end
        end
        StDrain: begin
          // The last tag leaving the pipe means nothing else is in flight.
          if (tag_out.valid && tag_out.last) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag for the address on the bus this cycle; it exits when its data is on dout.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = (state_q == StRead);
    tag_in.last  = (state_q == StRead) && (cnt_q == '0);
  end

  // Pipe is empty in idle; flushing there guards against any stale tag.
  rd_tag_pipe #(
    .Depth (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (state_q == StIdle),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Outputs: RAM pins from registers, read data gated so it reads zero when idle.
  always_comb begin
    ram_we    = ram_we_q;
    ram_addr  = ram_addr_q;
    ram_din   = ram_din_q;
    req_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    rd_valid  = tag_out.valid;
    rd_last   = tag_out.valid & tag_out.last;
    rd_data   = tag_out.valid ? ram_dout : '0;
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl with a behavioural RAM and a
// request-level timing/data model.
module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [3:0]  req_len = '0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_last;
  logic        busy;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  ram_access_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_len   (req_len),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural 256x16 RAM, read-first, one-cycle registered read.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  typedef struct {
    int          due;
    logic [15:0] data;
    logic        last;
  } rd_exp_t;
  typedef struct {
    int         due;
    logic [7:0] addr;
  } addr_exp_t;

  logic [15:0] shadow [256];
  rd_exp_t     rd_q [$];
  addr_exp_t   addr_q [$];
  int          next_ok = 0;
  int          wr_due = -1;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        chk_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(cyc + 1 >= next_ok));
      check("busy", 32'(busy), 32'(cyc + 1 < next_ok));
      check("ram_we", 32'(ram_we), 32'(cyc == wr_due));
      if (cyc == wr_due) begin
        check("wr_addr", 32'(ram_addr), 32'(wr_addr));
        check("wr_din", 32'(ram_din), 32'(wr_data));
      end
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        check("rd_valid", 32'(rd_valid), 32'(1'b1));
        check("rd_data", 32'(rd_data), 32'(rd_q[0].data));
        check("rd_last", 32'(rd_last), 32'(rd_q[0].last));
        void'(rd_q.pop_front());
      end else begin
        check("rd_valid_idle", 32'(rd_valid), 32'(1'b0));
      end
      if (addr_q.size() > 0 && addr_q[0].due == cyc) begin
        check("rd_addr", 32'(ram_addr), 32'(addr_q[0].addr));
        void'(addr_q.pop_front());
      end
    end
  end

  // Present a request (called at a negedge) and hold it until the model says it is taken.
  task automatic issue(input logic we, input logic [7:0] a, input logic [15:0] d,
                       input logic [3:0] l, output int acc);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_len   = l;
    acc = (next_ok > cyc + 1) ? next_ok : cyc + 1;
    while (cyc + 1 < acc) @(negedge clk);
    @(posedge clk);
    if (we) begin
      shadow[a] = d;
      wr_due    = acc;
      wr_addr   = a;
      wr_data   = d;
      next_ok   = acc + 2;
    end else begin
      for (int i = 0; i <= int'(l); i++) begin
        rd_q.push_back('{acc + 1 + i, shadow[a + 8'(i)], (i == int'(l))});
        addr_q.push_back('{acc + i, a + 8'(i)});
      end
      next_ok = acc + int'(l) + 3;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
    check({tag, "_rd_data"}, 32'(rd_data), 32'(0));
    check({tag, "_rd_last"}, 32'(rd_last), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_ram_we"}, 32'(ram_we), 32'(0));
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'(0));
    check({tag, "_ram_din"}, 32'(ram_din), 32'(0));
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 256; i++) begin
      mem[i]    <= 16'(i * 7 + 3);
      shadow[i] = 16'(i * 7 + 3);
    end

    // Reset state.
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    #1 chk_en = 1'b1;
    @(negedge clk);

    // Single write.
    issue(1'b1, 8'h10, 16'hBEEF, 4'h0, acc);
    idle(2);

    // Write then single-word read back.
    issue(1'b1, 8'h20, 16'h1234, 4'h0, acc);
    issue(1'b0, 8'h20, 16'h0000, 4'h0, acc);
    idle(2);

    // Wrapping burst across 0xFF -> 0x00.
    issue(1'b1, 8'hFE, 16'hAAAA, 4'h0, acc);
    issue(1'b1, 8'hFF, 16'hBBBB, 4'h0, acc);
    issue(1'b1, 8'h00, 16'hCCCC, 4'h0, acc);
    issue(1'b1, 8'h01, 16'hDDDD, 4'h0, acc);
    issue(1'b0, 8'hFE, 16'h0000, 4'h3, acc);
    idle(1);

    // Second request held high during a 16-word burst.
    issue(1'b0, 8'h80, 16'h0000, 4'hF, acc);
    issue(1'b0, 8'h10, 16'h0000, 4'h2, acc);
    idle(6);

    // Reset after 5 of 16 words.
    issue(1'b0, 8'h40, 16'h0000, 4'hF, acc);
    while (cyc < acc + 5) @(negedge clk);
    #2;
    chk_en    = 1'b0;
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    check_all_zero("midreset");
    rd_q.delete();
    addr_q.delete();
    next_ok = 0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    #1 chk_en = 1'b1;
    idle(6);
    issue(1'b0, 8'h20, 16'h0000, 4'h0, acc);
    issue(1'b0, 8'hFE, 16'h0000, 4'h3, acc);
    idle(1);

    // Randomized mix of writes and bursts.
    for (int n = 0; n < 80; n++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), 4'($urandom), acc);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(24);
    check("rd_q_empty", 32'(rd_q.size()), 32'(0));
    check("addr_q_empty", 32'(addr_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
